// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int LINES_DEFAULT = 64;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_e;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines);
    return 30 - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side port and backing-memory channels of the data cache, bundled for connection.
// Memory request: a transfer happens on a posedge where mem_req_valid && mem_req_ready;
// while valid is high and ready low, all mem_req_* fields stay stable. The response
// channel has no ready: mem_resp_valid is a one-cycle pulse carrying mem_resp_data.
interface dcache_if;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [29:0] mem_req_addr;
  logic [3:0]  mem_req_we;
  logic [31:0] mem_req_data;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  logic [31:0] hit_count;
  logic [31:0] miss_count;

  // slave: the cache itself; master: pipeline stage 2 plus backing memory
  modport slave (
    input  dcache_addr, dcache_re, dcache_we, dcache_din,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output dcache_dout, stall,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_data,
    output hit_count, miss_count
  );

  modport master (
    output dcache_addr, dcache_re, dcache_we, dcache_din,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  dcache_dout, stall,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_data,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/data storage for one-word lines: combinational lookup, byte-merged store
// update on hit, whole-line fill, and synchronous clear of all valid bits.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = LINES_DEFAULT,
  parameter int IDX_W = idx_w(LINES_DEFAULT),
  parameter int TAG_W = tag_w(LINES_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             hit_o,
  output logic [31:0]      rd_data_o,
  input  logic             wr_en_i,
  input  logic [3:0]       wr_mask_i,
  input  logic [31:0]      wr_data_i,
  input  logic             fill_en_i,
  input  logic [31:0]      fill_data_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];
  logic [31:0]      line_d;

  assign hit_o     = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
  assign rd_data_o = data_q[idx_i];

  // A fill replaces the whole word; a store only touches the enabled byte lanes.
  always_comb begin
    line_d = data_q[idx_i];
    for (int b = 0; b < 4; b++) begin
      if (wr_mask_i[b]) line_d[8*b +: 8] = wr_data_i[8*b +: 8];
    end
    if (fill_en_i) line_d = fill_data_i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en_i || (wr_en_i && hit_o)) data_q[idx_i] <= line_d;
    if (fill_en_i) tag_q[idx_i] <= tag_i;
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache: request FSM, pipeline
// stall generation, registered load data and hit/miss counters.
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES = LINES_DEFAULT
) (
  input  logic     clk,
  input  logic     reset,
  dcache_if.slave  bus,
  output state_e   state_o
);

  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             is_store, is_read, hit;
  logic [31:0]      line_data;
  logic             fill_en, wr_en;
  logic             stall, req_valid;
  logic [3:0]       req_we;
  logic [31:0]      dout_q, dout_d;
  logic [31:0]      hit_q, hit_d;
  logic [31:0]      miss_q, miss_d;
  logic             unused_byte_offset;

  assign idx      = bus.dcache_addr[IDX_W+1:2];
  assign tag      = bus.dcache_addr[31:IDX_W+2];
  assign is_store = |bus.dcache_we;
  assign is_read  = bus.dcache_re && !is_store;
  assign unused_byte_offset = ^bus.dcache_addr[1:0];

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk         (clk),
    .reset       (reset),
    .idx_i       (idx),
    .tag_i       (tag),
    .hit_o       (hit),
    .rd_data_o   (line_data),
    .wr_en_i     (wr_en),
    .wr_mask_i   (bus.dcache_we),
    .wr_data_i   (bus.dcache_din),
    .fill_en_i   (fill_en),
    .fill_data_i (bus.mem_resp_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (is_read && !hit && bus.mem_req_ready) state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (bus.mem_resp_valid) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Everything is gated off while reset is held so nothing leaks to memory or the pipeline.
  always_comb begin
    stall     = 1'b0;
    req_valid = 1'b0;
    req_we    = 4'b0000;
    fill_en   = 1'b0;
    wr_en     = 1'b0;
    dout_d    = dout_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    if (reset) begin
      case (state_q)
        ST_IDLE: begin
          if (is_store) begin
            req_valid = 1'b1;
            req_we    = bus.dcache_we;
            stall     = !bus.mem_req_ready;
            wr_en     = bus.mem_req_ready;
          end else if (is_read) begin
            if (hit) begin
              dout_d = line_data;
              hit_d  = hit_q + 32'd1;
            end else begin
              req_valid = 1'b1;
              stall     = 1'b1;
              if (bus.mem_req_ready) miss_d = miss_q + 32'd1;
            end
          end
        end
        ST_RD_WAIT: begin
          stall = !bus.mem_resp_valid;
          if (bus.mem_resp_valid) begin
            fill_en = 1'b1;
            dout_d  = bus.mem_resp_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q <= '0;
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      dout_q <= dout_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign bus.stall         = stall;
  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_we    = req_we;
  assign bus.mem_req_addr  = bus.dcache_addr[31:2];
  assign bus.mem_req_data  = bus.dcache_din;
  assign bus.dcache_dout   = dout_q;
  assign bus.hit_count     = hit_q;
  assign bus.miss_count    = miss_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: directed scenarios plus random traffic against a word-level memory
// and line-occupancy model.
module tb_dcache;
  import dcache_pkg::*;

  localparam int LINES = 64;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  state_e dbg_state;

  always #5 clk = ~clk;

  dcache_if bus();

  dcache #(.LINES(LINES)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .state_o (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: backing memory by word address, and which word each line holds
  logic [31:0] exp_q[$];
  logic [31:0] mem_m [int];
  int          line_w [LINES];
  bit          line_v [LINES];
  int          exp_hit = 0;
  int          exp_miss = 0;

  // memory responder knobs and state
  bit rand_ready = 1'b0;
  int ready_hold = 0;
  int resp_gap   = 0;
  bit pend       = 1'b0;
  int pend_cnt   = 0;
  int pend_w     = 0;
  int req_cnt    = 0;

  function automatic logic [31:0] mem_rd(input int w);
    logic [31:0] ww;
    if (mem_m.exists(w)) return mem_m[w];
    ww = w;
    return (ww * 32'h9E37_79B1) ^ 32'h5A5A_1357;
  endfunction

  task automatic mem_wr(input int w, input logic [3:0] mask, input logic [31:0] data);
    logic [31:0] cur;
    cur = mem_rd(w);
    for (int b = 0; b < 4; b++) if (mask[b]) cur[8*b +: 8] = data[8*b +: 8];
    mem_m[w] = cur;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) line_v[i] = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
    exp_q.delete();
  endtask

  // Backing memory: accepts at negedge (inputs are stable until the next posedge),
  // drives ready/response shortly after each posedge.
  initial begin
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) begin
        req_cnt++;
        if (bus.mem_req_we == 4'b0000) begin
          pend     = 1'b1;
          pend_cnt = resp_gap;
          pend_w   = int'({2'b00, bus.mem_req_addr});
        end else begin
          mem_wr(int'({2'b00, bus.mem_req_addr}), bus.mem_req_we, bus.mem_req_data);
        end
      end
      @(posedge clk);
      #2;
      bus.mem_resp_valid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = mem_rd(pend_w);
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (ready_hold > 0) begin
        bus.mem_req_ready = 1'b0;
        ready_hold--;
      end else begin
        bus.mem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // One CPU access held until stall drops; exp_stall < 0 skips the stall-count check.
  task automatic do_access(input logic [31:0] a, input logic re, input logic [3:0] we,
                           input logic [31:0] din, input int exp_stall, input int hold,
                           input string name);
    int w, idx, reqs_before, exp_reqs, stalls;
    bit st, rd, hit, done;
    logic [31:0] exp_dout;
    w   = int'({2'b00, a[31:2]});
    idx = w % LINES;
    st  = (we != 4'b0000);
    rd  = re && !st;
    exp_reqs = st ? 1 : 0;
    if (rd) begin
      hit = line_v[idx] && (line_w[idx] == w);
      if (hit) begin
        exp_hit++;
      end else begin
        exp_miss++;
        exp_reqs = 1;
        line_v[idx] = 1'b1;
        line_w[idx] = w;
      end
      exp_q.push_back(mem_rd(w));
    end
    reqs_before = req_cnt;

    @(posedge clk);
    #1;
    bus.dcache_addr = a;
    bus.dcache_re   = re;
    bus.dcache_we   = we;
    bus.dcache_din  = din;
    ready_hold      = hold;

    stalls = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.mem_req_valid === 1'b1) begin
        n_checks++;
        if (bus.mem_req_addr !== a[31:2] || bus.mem_req_we !== (st ? we : 4'b0000) ||
            (st && bus.mem_req_data !== din)) begin
          n_errors++;
          $display("FAIL %s req_fields: got addr=%h we=%b data=%h expected addr=%h we=%b data=%h",
                   name, bus.mem_req_addr, bus.mem_req_we, bus.mem_req_data,
                   a[31:2], (st ? we : 4'b0000), din);
        end
      end
      if (bus.stall === 1'b0) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 200) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s timeout: stall still high after %0d cycles, expected release", name, stalls);
          done = 1'b1;
        end
      end
    end

    @(posedge clk);
    #1;
    bus.dcache_re = 1'b0;
    bus.dcache_we = 4'b0000;
    @(negedge clk);

    n_checks++;
    if (req_cnt - reqs_before !== exp_reqs) begin
      n_errors++;
      $display("FAIL %s mem_requests: got %0d expected %0d", name, req_cnt - reqs_before, exp_reqs);
    end
    if (rd) begin
      exp_dout = exp_q.pop_front();
      n_checks++;
      if (bus.dcache_dout !== exp_dout) begin
        n_errors++;
        $display("FAIL %s dout: got %h expected %h", name, bus.dcache_dout, exp_dout);
      end
    end
    if (exp_stall >= 0) begin
      n_checks++;
      if (stalls !== exp_stall) begin
        n_errors++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stall);
      end
    end
    n_checks++;
    if (bus.hit_count !== 32'(exp_hit) || bus.miss_count !== 32'(exp_miss)) begin
      n_errors++;
      $display("FAIL %s counters: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
               name, bus.hit_count, bus.miss_count, exp_hit, exp_miss);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.dcache_addr = 32'h0000_0100;
    bus.dcache_re   = 1'b1;
    bus.dcache_we   = 4'b0000;
    bus.dcache_din  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got stall=%b req_valid=%b expected 0 0", bus.stall, bus.mem_req_valid);
    end
    n_checks++;
    if (bus.dcache_dout !== 32'h0 || bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_regs: got dout=%h hit=%0d miss=%0d expected 0 0 0",
               bus.dcache_dout, bus.hit_count, bus.miss_count);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk);
    #1;
    bus.dcache_re = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_read_miss();
    mem_m[32'h40] = 32'hDEAD_BEEF;
    resp_gap = 2;
    do_access(32'h0000_0100, 1'b1, 4'b0000, 32'h0, 3, 0, "read_miss");
  endtask

  task automatic test_read_hit();
    do_access(32'h0000_0100, 1'b1, 4'b0000, 32'h0, 0, 0, "read_hit");
  endtask

  task automatic test_store_hit();
    do_access(32'h0000_0100, 1'b0, 4'b0011, 32'h0000_1234, 0, 0, "store_hit");
    do_access(32'h0000_0100, 1'b1, 4'b0000, 32'h0, 0, 0, "read_after_store");
    n_checks++;
    if (bus.dcache_dout !== 32'hDEAD_1234) begin
      n_errors++;
      $display("FAIL merged_word: got %h expected %h", bus.dcache_dout, 32'hDEAD_1234);
    end
  endtask

  task automatic test_store_backpressure();
    resp_gap = 0;
    do_access(32'h0000_0200, 1'b0, 4'b1111, 32'hCAFE_F00D, 3, 3, "store_miss_hold");
    do_access(32'h0000_0200, 1'b1, 4'b0000, 32'h0, 1, 0, "read_no_allocate");
  endtask

  task automatic test_conflict();
    resp_gap = 1;
    do_access(32'h0000_0100, 1'b1, 4'b0000, 32'h0, 2, 0, "conflict_a");
    do_access(32'h0000_0100 + 4 * LINES, 1'b1, 4'b0000, 32'h0, 2, 0, "conflict_b");
    do_access(32'h0000_0100, 1'b1, 4'b0000, 32'h0, 2, 0, "conflict_a_again");
  endtask

  task automatic test_reset_mid_miss();
    resp_gap = 4;
    @(posedge clk);
    #1;
    bus.dcache_addr = 32'h0000_0300;
    bus.dcache_re   = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b1 || bus.mem_req_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL midmiss_request: got stall=%b req_valid=%b expected 1 1", bus.stall, bus.mem_req_valid);
    end
    @(posedge clk);
    #1;
    bus.dcache_re = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_errors++;
      $display("FAIL midmiss_stall_in_reset: got %b expected 0", bus.stall);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.dcache_dout !== 32'h0 || dbg_state !== ST_IDLE || bus.miss_count !== 32'h0) begin
      n_errors++;
      $display("FAIL midmiss_stale_resp: got dout=%h state=%0d miss=%0d expected 0 %0d 0",
               bus.dcache_dout, dbg_state, bus.miss_count, ST_IDLE);
    end
    resp_gap = 0;
    do_access(32'h0000_0300, 1'b1, 4'b0000, 32'h0, 1, 0, "midmiss_reread");
  endtask

  task automatic test_random();
    int w;
    logic [31:0] a;
    logic re;
    logic [3:0] we;
    int kind;
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      w    = $urandom_range(0, 7) + LINES * $urandom_range(0, 3);
      a    = {w[29:0], 2'($urandom_range(0, 3))};
      kind = $urandom_range(0, 5);
      re   = 1'b1;
      we   = 4'b0000;
      if (kind == 0) begin
        re = 1'b0;
        we = 4'($urandom_range(1, 15));
      end else if (kind == 1) begin
        we = 4'($urandom_range(1, 15));
      end
      resp_gap = $urandom_range(0, 3);
      do_access(a, re, we, $urandom, -1, 0, "random");
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_store_hit();
    test_store_backpressure();
    test_conflict();
    test_reset_mid_miss();
    test_random();
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache that answers the CPU data-memory port driven by pipeline stage 2 (`dcache_addr/re/we/din` in, `dcache_dout` back) and forwards misses and all stores to backing memory over a valid/ready request channel and a valid-only response channel. It drives the pipeline-wide `stall` line whenever an access cannot finish at the coming clock edge, so stage 2 holds its request stable until completion.

## Interface
- `LINES`, 64: number of one-word lines (power of 2); `IDX_W = log2(LINES)`, `TAG_W = 30 - IDX_W`
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled at posedge)
- `dcache_addr`  in  32  byte address; bits [1:0] ignored
- `dcache_re`  in  1  read request
- `dcache_we`  in  4  byte write mask; nonzero = store
- `dcache_din`  in  32  store data, already lane-aligned
- `dcache_dout`  out  32  load data, registered
- `stall`  out  1  combinational; 1 = current request does not complete at next posedge
- `mem_req_valid`  out  1  memory request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_addr`  out  30  word address (`dcache_addr[31:2]`)
- `mem_req_we`  out  4  byte mask; 0 = read
- `mem_req_data`  out  32  store data
- `mem_resp_valid`  in  1  read data valid (one-cycle pulse)
- `mem_resp_data`  in  32  read data
- `hit_count`, `miss_count`  out  32 each  performance counters

## Operation
- Address split: index = `addr[IDX_W+1:2]`, tag = `addr[31:IDX_W+2]`; tag/valid/data arrays in flops, read combinationally.
- Request = `dcache_we != 0` or `dcache_re`; both set → treated as store, read ignored.
- FSM states: IDLE, RD_WAIT.
- IDLE, read hit: `stall`=0; at posedge `dcache_dout` ← line data, `hit_count`+1.
- IDLE, read miss: `mem_req_valid`=1, `mem_req_we`=0, `stall`=1; on posedge with `mem_req_ready` → RD_WAIT, `miss_count`+1.
- RD_WAIT: `mem_req_valid`=0; `stall` = !`mem_resp_valid`; on posedge with `mem_resp_valid`: line ← data, tag written, valid←1, `dcache_dout` ← `mem_resp_data`, → IDLE.
- IDLE, store: `mem_req_valid`=1, `mem_req_we`=`dcache_we`, `mem_req_data`=`dcache_din`; `stall` = !`mem_req_ready`; at accepting posedge, on tag hit merge `dcache_din` into line per byte mask; on miss no allocate. Stores count neither hit nor miss.
- No request in IDLE: `stall`=0, `mem_req_valid`=0, no state change.
- Inputs ignored in RD_WAIT (stage 2 holds them stable under stall).
- `mem_resp_valid` in IDLE is ignored.
- Counters wrap at 2^32.

## Timing
- Reset values: state IDLE, all valid bits 0, `dcache_dout`=0, `hit_count`=`miss_count`=0; `stall`=0 and `mem_req_valid`=0 while `reset`=0.
- Read hit: 0 stall cycles, data valid after the request's posedge.
- Read miss: `stall` high from first request cycle until cycle in which `mem_resp_valid`=1 (inclusive low there); minimum 2 edges.
- Store: completes at first posedge with `mem_req_ready`=1; 0 stall cycles if ready already high.
- `mem_req_*` held stable while `mem_req_valid`=1 and `mem_req_ready`=0.
- Reset mid-miss: returns to IDLE, outstanding response dropped, line not filled.
- Store to a line with fill in progress cannot occur (stall).

## Structure
- `dcache_pkg`: state enum, `LINES` default, index/tag width functions.
- Sub-module `dcache_array`: tag/valid/data flops, combinational hit/read, byte-masked write and fill port, synchronous valid clear.
- Top `dcache`: FSM, stall/request logic, output register, counters.

## Test plan
- Reset, read 0x0000_0100 with ready=1, resp 2 cycles later 0xDEAD_BEEF → stall high 3 cycles, `dcache_dout`=0xDEADBEEF, `miss_count`=1.
- Re-read 0x100 → `stall`=0, dout 0xDEADBEEF next edge, `hit_count`=1, no memory request.
- Store 0x100 mask 4'b0011 data 0x0000_1234, ready=1 → one mem request mask 0011, no stall; read 0x100 hits 0xDEAD1234.
- Store to uncached 0x200, ready low 3 cycles → `stall` 3 cycles, request stable; read 0x200 then misses.
- Read 0x100 then 0x100 + 4·LINES (same index, different tag) → second misses, refills; first then misses again.
- Assert reset in RD_WAIT, then resp pulse → ignored, dout 0, next read of that address misses.
